// File: rtl/calc_engine.sv
// Add / subtract / iterative signed multiply engine for 80-bit operands.
// The 160-bit result leaves as four 48-bit tagged words on a valid/ready stream.
module calc_engine #(
    parameter int OPW  = 80,
    parameter int RESW = 160,
    parameter int SEGW = 40
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    input  logic [2:0]      app,
    input  logic            sel,
    input  logic            en,
    output logic [47:0]     dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            busy,
    output logic            overrun
);
    localparam int NSEG = RESW / SEGW;
    localparam int IDXW = $clog2(NSEG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_SIGN,
        S_PACK
    } state_t;

    state_t state_q, state_d;

    logic [OPW-1:0]  a_q, b_q;
    logic [2:0]      app_q;
    logic            sel_q;
    logic            en_dly_q;
    logic [2:0]      op_app_q;
    logic            neg_q;
    logic [OPW-1:0]  mcand_q;
    logic [RESW-1:0] res_q;
    logic [6:0]      cnt_q;
    logic [IDXW-1:0] idx_q;
    logic            overrun_q;

    logic            launch;
    logic            op_ok;
    logic            is_mul;
    logic [OPW-1:0]  mag_a, mag_b;
    logic [OPW:0]    sum_ab;
    logic [OPW:0]    mul_acc;
    logic [SEGW-1:0] seg_words [NSEG];

    // The launch cycle reads the snapshot taken one cycle earlier, since the
    // collector may already have cleared a/b when it drops en.
    assign launch = en_dly_q & ~en;
    assign op_ok  = (app_q == 3'b001) || (app_q == 3'b010) || (app_q == 3'b011);
    assign is_mul = (app_q == 3'b011);

    // Unsigned magnitudes; -2^79 maps cleanly to 2^79 in 80 bits.
    assign mag_a = a_q[OPW-1] ? (~a_q + OPW'(1)) : a_q;
    assign mag_b = b_q[OPW-1] ? (~b_q + OPW'(1)) : b_q;

    always_comb begin
        sum_ab = {a_q[OPW-1], a_q} + {b_q[OPW-1], b_q};
        if (op_app_q == 3'b010) begin
            if (sel_q) begin
                sum_ab = {b_q[OPW-1], b_q} - {a_q[OPW-1], a_q};
            end else begin
                sum_ab = {a_q[OPW-1], a_q} - {b_q[OPW-1], b_q};
            end
        end
    end

    // Product register holds {accumulator, remaining multiplier bits}.
    assign mul_acc = {1'b0, res_q[RESW-1:OPW]} + {1'b0, mcand_q & {OPW{res_q[0]}}};

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            assign seg_words[gi] = res_q[RESW-1-gi*SEGW -: SEGW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dout_valid = 1'b0;
        busy       = (state_q != S_IDLE);
        dout       = '0;
        case (state_q)
            S_IDLE: begin
                if (launch && op_ok) begin
                    state_d = is_mul ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: state_d = S_PACK;
            S_MUL: begin
                if (cnt_q == 7'(OPW - 1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: state_d = S_PACK;
            S_PACK: begin
                dout_valid = 1'b1;
                dout       = {op_app_q, 2'b00, 1'b0, idx_q, seg_words[idx_q]};
                if (dout_ready && (idx_q == IDXW'(NSEG - 1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_q       <= '0;
            b_q       <= '0;
            app_q     <= '0;
            sel_q     <= 1'b0;
            en_dly_q  <= 1'b0;
            op_app_q  <= '0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            en_dly_q <= en;
            if (en) begin
                a_q   <= a;
                b_q   <= b;
                app_q <= app;
                sel_q <= sel;
            end

            if (launch) begin
                if (state_q != S_IDLE) begin
                    overrun_q <= 1'b1;
                end else if (op_ok) begin
                    overrun_q <= 1'b0;
                    op_app_q  <= app_q;
                    neg_q     <= a_q[OPW-1] ^ b_q[OPW-1];
                    mcand_q   <= mag_a;
                    res_q     <= {{(RESW-OPW){1'b0}}, mag_b};
                    cnt_q     <= '0;
                    idx_q     <= '0;
                end
            end

            case (state_q)
                S_EXEC: res_q <= {{(RESW-OPW-1){sum_ab[OPW]}}, sum_ab};
                S_MUL: begin
                    res_q <= {mul_acc, res_q[OPW-1:1]};
                    cnt_q <= cnt_q + 7'd1;
                end
                S_SIGN: begin
                    if (neg_q) begin
                        res_q <= ~res_q + RESW'(1);
                    end
                end
                S_PACK: begin
                    if (dout_ready) begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine: wide-integer result model feeding a word
// scoreboard, plus literal expectations for latency, flags and words.
`timescale 1ns/1ps
module tb_calc_engine;
    logic         clk = 1'b0;
    logic         rstn;
    logic [79:0]  a_in, b_in;
    logic [2:0]   app_in;
    logic         sel_in;
    logic         en;
    logic [47:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         overrun;

    int checks = 0;
    int failures = 0;

    logic [47:0] exp_q[$];
    logic [47:0] rec[$];
    logic        hold_pending = 1'b0;
    logic [47:0] held_word;

    calc_engine dut (
        .clk(clk), .rstn(rstn), .a(a_in), .b(b_in), .app(app_in), .sel(sel_in),
        .en(en), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact signed result from plain wide arithmetic, split into tagged words.
    task automatic push_model(input logic [79:0] a, input logic [79:0] b,
                              input logic [2:0] app, input logic sel);
        logic signed [159:0] ea, eb, r;
        ea = $signed(a);
        eb = $signed(b);
        case (app)
            3'b001:  r = ea + eb;
            3'b010:  r = sel ? (eb - ea) : (ea - eb);
            default: r = ea * eb;
        endcase
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({app, 2'b00, 3'(i), r[159-40*i -: 40]});
        end
    endtask

    // Leaves the bench inside the launch cycle L (en just dropped, a/b zeroed).
    task automatic do_launch(input logic [79:0] a, input logic [79:0] b, input logic [2:0] app,
                             input logic sel, input int ncyc, input bit push);
        a_in = a; b_in = b; app_in = app; sel_in = sel; en = 1'b1;
        repeat (ncyc) tick();
        en = 1'b0; a_in = '0; b_in = '0;
        if (push) push_model(a, b, app, sel);
    endtask

    task automatic wait_done();
        int n;
        tick();
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("done_timeout", (n >= 400), 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", dout_valid, 1'b1);
                if (dout_valid) chk("hold_stable", dout, held_word);
            end
            if (dout_valid && dout_ready) begin
                rec.push_back(dout);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none", dout);
                end else begin
                    chk("word", dout, exp_q.pop_front());
                end
                hold_pending = 1'b0;
            end else if (dout_valid) begin
                hold_pending = 1'b1;
                held_word = dout;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    logic [47:0] add_lit [4] = '{48'h2000_0000_0000, 48'h2100_0000_0000,
                                 48'h2200_0000_0000, 48'h2300_0000_000C};

    initial begin
        int n;
        int n_valid;
        rstn = 1'b0; en = 1'b0; a_in = '0; b_in = '0; app_in = '0; sel_in = 1'b0;
        dout_ready = 1'b1;
        repeat (3) tick();
        chk("rst_dout", dout, 48'h0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rstn = 1'b1;
        tick();

        // add 5+7, literal words and cycle-exact timing
        rec.delete();
        do_launch(80'd5, 80'd7, 3'b001, 1'b0, 3, 1'b1);
        tick();
        chk("add_l1_valid", dout_valid, 1'b0);
        chk("add_l1_busy", busy, 1'b1);
        tick();
        chk("add_l2_valid", dout_valid, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("add_word_lit", dout, add_lit[k]);
            tick();
        end
        chk("add_done_busy", busy, 1'b0);
        chk("add_done_valid", dout_valid, 1'b0);
        $display("txn add a=5 b=7 words=%0d", rec.size());

        // sub a-b
        rec.delete();
        do_launch(80'd5, 80'd7, 3'b010, 1'b0, 2, 1'b1);
        wait_done();
        chk("sub0_count", rec.size(), 4);
        if (rec.size() == 4) begin
            chk("sub0_w0", rec[0][39:0], 40'hFF_FFFF_FFFF);
            chk("sub0_w3", rec[3][39:0], 40'hFF_FFFF_FFFE);
        end
        $display("txn sub sel=0 words=%0d", rec.size());

        // sub b-a
        rec.delete();
        do_launch(80'd5, 80'd7, 3'b010, 1'b1, 2, 1'b1);
        wait_done();
        chk("sub1_count", rec.size(), 4);
        if (rec.size() == 4) begin
            chk("sub1_w0", rec[0][39:0], 40'h0);
            chk("sub1_w3", rec[3][39:0], 40'h2);
        end
        $display("txn sub sel=1 words=%0d", rec.size());

        // mul -3*4, latency L+82
        rec.delete();
        do_launch(-80'sd3, 80'd4, 3'b011, 1'b0, 2, 1'b1);
        n = 0;
        while (!dout_valid && n < 200) begin
            tick();
            n++;
        end
        chk("mul_latency", n, 82);
        wait_done();
        chk("mul_count", rec.size(), 4);
        if (rec.size() == 4) begin
            chk("mul_w0", rec[0][39:0], 40'hFF_FFFF_FFFF);
            chk("mul_w3", rec[3][39:0], 40'hFF_FFFF_FFF4);
        end
        $display("txn mul -3*4 latency=%0d words=%0d", n, rec.size());

        // mul (-2^79)^2 = 2^158
        rec.delete();
        do_launch(80'h8000_0000_0000_0000_0000, 80'h8000_0000_0000_0000_0000, 3'b011, 1'b0, 2, 1'b1);
        wait_done();
        chk("mulx_count", rec.size(), 4);
        if (rec.size() == 4) begin
            chk("mulx_w0", rec[0][39:0], 40'h40_0000_0000);
            chk("mulx_w1", rec[1][39:0], 40'h0);
            chk("mulx_w3", rec[3][39:0], 40'h0);
        end
        $display("txn mul extreme words=%0d", rec.size());

        // unsupported op code is ignored
        rec.delete();
        do_launch(80'd9, 80'd9, 3'b101, 1'b0, 2, 1'b0);
        tick();
        chk("badop_busy", busy, 1'b0);
        tick();
        chk("badop_valid", dout_valid, 1'b0);
        $display("txn badop app=5 busy=%0d", busy);

        // backpressure plus a launch while busy
        rec.delete();
        do_launch(-80'sd100, 80'd123456789, 3'b001, 1'b0, 2, 1'b1);
        for (int i = 0; i < 60; i++) begin
            dout_ready = i[0];
            if (i == 3) begin
                a_in = 80'd1; b_in = 80'd1; app_in = 3'b001; en = 1'b1;
            end
            if (i == 4) en = 1'b0;
            tick();
            if (i > 4 && !busy) break;
        end
        dout_ready = 1'b1;
        chk("bp_busy_end", busy, 1'b0);
        chk("bp_overrun", overrun, 1'b1);
        repeat (10) tick();
        chk("bp_count", rec.size(), 4);
        chk("bp_overrun_sticky", overrun, 1'b1);
        $display("txn add backpressure words=%0d overrun=%0d", rec.size(), overrun);

        // next accepted launch clears overrun
        rec.delete();
        do_launch(80'd1, 80'd2, 3'b001, 1'b0, 1, 1'b1);
        tick();
        chk("overrun_clear", overrun, 1'b0);
        wait_done();
        chk("clr_count", rec.size(), 4);
        $display("txn add after overrun words=%0d", rec.size());

        // reset in the middle of a multiply
        rec.delete();
        do_launch(80'd12345, -80'sd678, 3'b011, 1'b0, 2, 1'b0);
        repeat (40) tick();
        rstn = 1'b0;
        tick();
        chk("midrst_dout", dout, 48'h0);
        chk("midrst_valid", dout_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_overrun", overrun, 1'b0);
        rstn = 1'b1;
        n_valid = 0;
        repeat (120) begin
            tick();
            if (dout_valid) n_valid++;
        end
        chk("midrst_no_words", n_valid, 0);
        chk("midrst_rec", rec.size(), 0);
        $display("txn mul reset-mid-op valid_cycles=%0d", n_valid);

        // a few random operations against the model
        for (int t = 0; t < 6; t++) begin
            logic [79:0] ra, rb;
            logic [2:0]  rapp;
            ra = {$urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom()};
            rapp = 3'(1 + $urandom_range(0, 2));
            rec.delete();
            do_launch(ra, rb, rapp, 1'($urandom_range(0, 1)), 1 + $urandom_range(0, 2), 1'b1);
            wait_done();
            chk("rand_count", rec.size(), 4);
            $display("txn rand app=%0d a=%0h b=%0h words=%0d", rapp, ra, rb, rec.size());
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
